// File: rtl/aes_bus_frontend_if.sv
// Host bus and cipher-core signal bundle for aes_bus_frontend.
// The slave modport is the front end; master is the host/core side.
interface aes_bus_frontend_if #(
   parameter int DATA_W  = 32,
   parameter int BLOCK_W = 128,
   parameter int KEY_W   = 128
);
   logic               initiate;
   logic               RW;
   logic               adress;
   logic               selCypher;
   logic               start;
   logic [DATA_W-1:0]  data_in;
   logic [DATA_W-1:0]  data_out;
   logic               data_oe;
   logic               busy;
   logic               result_valid;
   logic               core_start;
   logic               core_decrypt;
   logic [BLOCK_W-1:0] core_msg;
   logic [KEY_W-1:0]   core_key;
   logic               core_done;
   logic [BLOCK_W-1:0] core_result;

   modport slave (
      input  initiate, RW, adress, selCypher, start, data_in, core_done, core_result,
      output data_out, data_oe, busy, result_valid, core_start, core_decrypt,
             core_msg, core_key
   );

   modport master (
      output initiate, RW, adress, selCypher, start, data_in, core_done, core_result,
      input  data_out, data_oe, busy, result_valid, core_start, core_decrypt,
             core_msg, core_key
   );
endinterface

// File: rtl/aes_bus_frontend.sv
// Word-serial host front end: assembles message/key, launches the core, serialises the result.
// core_start one cycle after an accepted start; reads are combinational; writes are dropped while RUN.
module aes_bus_frontend #(
   parameter int DATA_W  = 32,
   parameter int BLOCK_W = 128,
   parameter int KEY_W   = 128
) (
   input logic              clk,
   input logic              reset,
   aes_bus_frontend_if.slave bus
);
   localparam int NM  = BLOCK_W / DATA_W;
   localparam int NK  = KEY_W / DATA_W;
   localparam int MPW = (NM > 1) ? $clog2(NM) : 1;
   localparam int KPW = (NK > 1) ? $clog2(NK) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [BLOCK_W-1:0] msg_q, msg_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic [BLOCK_W-1:0] res_q, res_d;
   logic [MPW-1:0]     mptr_q, mptr_d;
   logic [KPW-1:0]     kptr_q, kptr_d;
   logic [MPW-1:0]     rptr_q, rptr_d;
   logic               busy_q, busy_d;
   logic               rvld_q, rvld_d;
   logic               cstart_q, cstart_d;
   logic               cdec_q, cdec_d;

   logic               wr_en, rd_en, start_ok;
   logic [DATA_W-1:0]  rd_word;

   always_comb begin
      wr_en    = bus.initiate & bus.RW & (state_q != S_RUN);
      rd_en    = bus.initiate & ~bus.RW & rvld_q;
      start_ok = bus.start & ~bus.initiate & (state_q != S_RUN);

      state_d  = state_q;
      msg_d    = msg_q;
      key_d    = key_q;
      res_d    = res_q;
      mptr_d   = mptr_q;
      kptr_d   = kptr_q;
      rptr_d   = rptr_q;
      busy_d   = busy_q;
      rvld_d   = rvld_q;
      cstart_d = 1'b0;
      cdec_d   = cdec_q;

      // Word 0 is the most significant word of each buffer.
      if (wr_en) begin
         if (!bus.adress) begin
            for (int i = 0; i < NM; i++)
               if (mptr_q == MPW'(i))
                  msg_d[(NM-1-i)*DATA_W +: DATA_W] = bus.data_in;
            mptr_d = (mptr_q == MPW'(NM-1)) ? '0 : mptr_q + 1'b1;
         end else begin
            for (int i = 0; i < NK; i++)
               if (kptr_q == KPW'(i))
                  key_d[(NK-1-i)*DATA_W +: DATA_W] = bus.data_in;
            kptr_d = (kptr_q == KPW'(NK-1)) ? '0 : kptr_q + 1'b1;
         end
      end

      if (rd_en)
         rptr_d = (rptr_q == MPW'(NM-1)) ? '0 : rptr_q + 1'b1;

      if (start_ok) begin
         state_d  = S_RUN;
         cstart_d = 1'b1;
         cdec_d   = ~bus.selCypher;
         busy_d   = 1'b1;
         rvld_d   = 1'b0;
         mptr_d   = '0;
         kptr_d   = '0;
         rptr_d   = '0;
      end else if (state_q == S_RUN && bus.core_done) begin
         res_d   = bus.core_result;
         rvld_d  = 1'b1;
         busy_d  = 1'b0;
         state_d = S_DONE;
      end
   end

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NM; i++)
         if (rptr_q == MPW'(i))
            rd_word = res_q[(NM-1-i)*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         msg_q    <= '0;
         key_q    <= '0;
         res_q    <= '0;
         mptr_q   <= '0;
         kptr_q   <= '0;
         rptr_q   <= '0;
         busy_q   <= 1'b0;
         rvld_q   <= 1'b0;
         cstart_q <= 1'b0;
         cdec_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         msg_q    <= msg_d;
         key_q    <= key_d;
         res_q    <= res_d;
         mptr_q   <= mptr_d;
         kptr_q   <= kptr_d;
         rptr_q   <= rptr_d;
         busy_q   <= busy_d;
         rvld_q   <= rvld_d;
         cstart_q <= cstart_d;
         cdec_q   <= cdec_d;
      end
   end

   assign bus.data_oe      = rd_en;
   assign bus.data_out     = rd_en ? rd_word : '0;
   assign bus.busy         = busy_q;
   assign bus.result_valid = rvld_q;
   assign bus.core_start   = cstart_q;
   assign bus.core_decrypt = cdec_q;
   assign bus.core_msg     = msg_q;
   assign bus.core_key     = key_q;
endmodule
